// File: rtl/clz_16.sv
// Registered 16-bit count-leading-zeros unit with a balanced merge tree.
// out[4] is set only for an all-zero operand so wider CLZ trees can chain halves.
module clz_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in,
  output logic        out_valid,
  output logic [4:0]  out,
  output logic        all_zero
);

  logic [7:0]      z2;
  logic [7:0]      c2;
  logic [3:0]      z4;
  logic [3:0][1:0] c4;
  logic [1:0]      z8;
  logic [1:0][2:0] c8;
  logic            z16;
  logic [3:0]      c16;
  logic [4:0]      clz_next;

  // Each merge takes the upper count, or half_width + lower count when the upper half is empty.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      z2[i] = ~(in[2*i+1] | in[2*i]);
      c2[i] = ~in[2*i+1];
    end
    for (int i = 0; i < 4; i++) begin
      z4[i] = z2[2*i+1] & z2[2*i];
      c4[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      z8[i] = z4[2*i+1] & z4[2*i];
      c8[i] = z4[2*i+1] ? {1'b1, c4[2*i]} : {1'b0, c4[2*i+1]};
    end
    z16      = z8[1] & z8[0];
    c16      = z8[1] ? {1'b1, c8[0]} : {1'b0, c8[1]};
    clz_next = z16 ? 5'd16 : {1'b0, c16};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= 5'd0;
      all_zero  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out      <= clz_next;
        all_zero <= z16;
      end
    end
  end

endmodule

// File: tb/tb_clz_16.sv
// Self-checking bench for clz_16: directed cases plus random operands against a bit-scan model.
module tb_clz_16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in;
  logic        out_valid;
  logic [4:0]  out;
  logic        all_zero;

  int tests_run;
  int tests_failed;

  logic [4:0] exp_out;
  logic       exp_zero;
  logic       exp_valid;

  clz_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .all_zero  (all_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] clz_ref(input logic [15:0] d);
    int n;
    n = 0;
    for (int b = 15; b >= 0; b--) begin
      if (d[b]) break;
      n++;
    end
    return 5'(n);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".valid"}, 16'(out_valid), 16'(exp_valid));
    check({tag, ".out"}, 16'(out), 16'(exp_out));
    check({tag, ".zero"}, 16'(all_zero), 16'(exp_zero));
  endtask

  // Drive one operand, step one clock, and advance the expected registered state.
  task automatic apply_stimulus(input logic v, input logic [15:0] d);
    in_valid = v;
    in       = d;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      exp_out  = clz_ref(d);
      exp_zero = (d == 16'h0000);
    end
  endtask

  task automatic clear_model();
    exp_valid = 1'b0;
    exp_out   = 5'd0;
    exp_zero  = 1'b0;
  endtask

  logic [15:0] dir_vals [5];
  logic [15:0] rnd;
  logic        rv;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    dir_vals[0] = 16'hFFFF;
    dir_vals[1] = 16'h00FF;
    dir_vals[2] = 16'h0001;
    dir_vals[3] = 16'h0F0F;
    dir_vals[4] = 16'h7FFF;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    in       = 16'h8000;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hold");

    rst_n = 1'b1;
    apply_stimulus(1'b1, 16'h8000);
    check_output("reset_release");
    check("msb_count", 16'(out), 16'd0);

    apply_stimulus(1'b1, 16'h0000);
    check_output("zero_operand");
    check("zero_literal", 16'(out), 16'd16);

    // One-hot sweep with in_valid held high: every cycle must be a valid result.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 16'(1) << i);
      check_output($sformatf("onehot%0d", i));
      check($sformatf("onehot%0d_lit", i), 16'(out), 16'(15 - i));
    end

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, dir_vals[i]);
      check_output($sformatf("dontcare%0d", i));
    end

    apply_stimulus(1'b1, 16'h0010);
    check_output("gate_valid");
    check("gate_valid_lit", 16'(out), 16'd11);
    apply_stimulus(1'b0, 16'h0000);
    check_output("gate_hold");
    check("gate_hold_lit", 16'(out), 16'd11);

    for (int i = 0; i < 200; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rnd = 16'($urandom) >> $urandom_range(0, 16);
      apply_stimulus(rv, rnd);
      check_output($sformatf("rand%0d", i));
    end

    apply_stimulus(1'b1, 16'h0001);
    check_output("pre_async");
    apply_stimulus(1'b1, 16'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_output("async_reset");
    @(posedge clk);
    #1;
    check_output("async_reset_held");
    rst_n = 1'b1;
    apply_stimulus(1'b1, 16'h0100);
    check_output("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
